// File: rtl/keccak_pkg.sv
// Shared constants and state encoding for the Keccak-512 output serializer.
// The serializer and its host interface both import this package.
package keccak_pkg;

  localparam int DIGEST_W = 512;
  localparam int OUT_W    = 64;
  localparam int NWORDS   = DIGEST_W / OUT_W;
  localparam int CNT_W    = $clog2(NWORDS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef logic [CNT_W-1:0] count_t;

  localparam count_t LAST_WORD = count_t'(NWORDS - 1);

endpackage

// File: rtl/keccak_out_serializer512_if.sv
// Digest-in / word-out bundle between the permutation core, the serializer and the host.
// The master side drives the digest and the host ack; the slave side is the serializer.
interface keccak_out_serializer512_if;

  logic [keccak_pkg::DIGEST_W-1:0] in;
  logic                            in_ready;
  logic                            busy;
  logic [keccak_pkg::OUT_W-1:0]    out;
  logic                            out_ready;
  logic                            out_ack;
  logic                            is_last;
  logic                            overrun;

  modport master (
    output in, in_ready, out_ack,
    input  busy, out, out_ready, is_last, overrun
  );

  modport slave (
    input  in, in_ready, out_ack,
    output busy, out, out_ready, is_last, overrun
  );

endinterface

// File: rtl/keccak_out_serializer512.sv
// Parallel-to-serial stage: captures a 512-bit digest in one cycle and streams it
// to the host as eight 64-bit words, most significant word first, under valid/ack.
module keccak_out_serializer512
  import keccak_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  keccak_out_serializer512_if.slave    bus
);

  state_t                state, state_nxt;
  count_t                count, count_nxt;
  logic [DIGEST_W-1:0]   shreg, shreg_nxt;
  logic                  overrun_q, overrun_nxt;
  logic                  last;

  assign last = (state == SEND) && (count == LAST_WORD);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_nxt   = state;
    count_nxt   = count;
    shreg_nxt   = shreg;
    overrun_nxt = overrun_q;

    case (state)
      IDLE: begin
        if (bus.in_ready) begin
          shreg_nxt = bus.in;
          count_nxt = '0;
          state_nxt = SEND;
        end
      end

      SEND: begin
        if (bus.out_ack) begin
          if (last) begin
            // A new digest arriving with the final ack is handed off with no bubble.
            count_nxt = '0;
            if (bus.in_ready) shreg_nxt = bus.in;
            else              state_nxt = IDLE;
          end else begin
            shreg_nxt = {shreg[DIGEST_W-OUT_W-1:0], {OUT_W{1'b0}}};
            count_nxt = count + count_t'(1);
          end
        end
        if (bus.in_ready && !(bus.out_ack && last)) overrun_nxt = 1'b1;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the shift register is reset too so out reads 0 in IDLE after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      shreg     <= '0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_nxt;
      count     <= count_nxt;
      shreg     <= shreg_nxt;
      overrun_q <= overrun_nxt;
    end
  end

  // All outputs decode directly from registers, so an async reset clears them at once.
  assign bus.busy      = (state == SEND);
  assign bus.out_ready = (state == SEND);
  assign bus.out       = shreg[DIGEST_W-1 -: OUT_W];
  assign bus.is_last   = last;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_keccak_out_serializer512.sv
// Directed bench for keccak_out_serializer512: full-rate streaming, ack stalls,
// dropped pulses, back-to-back hand-off and asynchronous reset mid-stream.
module tb_keccak_out_serializer512;

  logic clk = 1'b0;
  logic reset;

  int n_cmp = 0;
  int n_err = 0;

  keccak_out_serializer512_if bus ();

  keccak_out_serializer512 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  logic [511:0] d_dig;
  logic [511:0] e_dig;

  function automatic logic [63:0] word_d(input int i);
    logic [3:0] nib;
    nib = 4'(i + 1);
    return {16{nib}};
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_digest(input logic [511:0] dig, input logic ack);
    bus.in       = dig;
    bus.in_ready = 1'b1;
    bus.out_ack  = ack;
    step();
    bus.in_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int k;
    logic ack_t;

    for (int i = 0; i < 8; i++) d_dig[511 - 64*i -: 64] = word_d(i);
    e_dig = {8{64'hAAAA_AAAA_AAAA_AAAA}};

    bus.in       = '0;
    bus.in_ready = 1'b0;
    bus.out_ack  = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    step();
    reset = 1'b0;

    // 1: reset then idle
    for (int i = 0; i < 10; i++) step();
    check("t1_out_ready", 512'(bus.out_ready), 512'(0));
    check("t1_busy",      512'(bus.busy),      512'(0));
    check("t1_overrun",   512'(bus.overrun),   512'(0));
    check("t1_out",       512'(bus.out),       512'(0));
    check("t1_is_last",   512'(bus.is_last),   512'(0));

    // 2: full-rate streaming with ack held
    start_digest(d_dig, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_word%0d", i), 512'(bus.out), 512'(word_d(i)));
      check($sformatf("t2_rdy%0d", i),  512'(bus.out_ready), 512'(1));
      check($sformatf("t2_last%0d", i), 512'(bus.is_last), 512'(i == 7));
      step();
    end
    check("t2_end_ready", 512'(bus.out_ready), 512'(0));
    check("t2_end_busy",  512'(bus.busy),      512'(0));
    check("t2_end_last",  512'(bus.is_last),   512'(0));
    bus.out_ack = 1'b0;
    step();

    // 3: stalled then toggled ack
    start_digest(d_dig, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_hold%0d", i), 512'(bus.out), 512'(word_d(0)));
      step();
    end
    k = 0;
    ack_t = 1'b1;
    for (int c = 0; c < 40 && k < 8; c++) begin
      check($sformatf("t3_word%0d_c%0d", k, c), 512'(bus.out), 512'(word_d(k)));
      check($sformatf("t3_last%0d_c%0d", k, c), 512'(bus.is_last), 512'(k == 7));
      bus.out_ack = ack_t;
      step();
      if (ack_t) k++;
      ack_t = !ack_t;
    end
    bus.out_ack = 1'b0;
    check("t3_all_words", 512'(k), 512'(8));
    check("t3_end_ready", 512'(bus.out_ready), 512'(0));
    step();

    // 4: in_ready during streaming is dropped and sets overrun
    start_digest(d_dig, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_word%0d", i),  512'(bus.out), 512'(word_d(i)));
      check($sformatf("t4_ovr%0d", i),   512'(bus.overrun), 512'(i >= 3));
      if (i == 2) begin
        bus.in       = e_dig;
        bus.in_ready = 1'b1;
      end
      step();
      bus.in_ready = 1'b0;
    end
    bus.out_ack = 1'b0;
    check("t4_end_ready", 512'(bus.out_ready), 512'(0));
    for (int i = 0; i < 4; i++) step();
    check("t4_ovr_sticky", 512'(bus.overrun), 512'(1));
    do_reset();
    check("t4_ovr_cleared", 512'(bus.overrun), 512'(0));

    // 5: hand-off on the final ack
    start_digest(d_dig, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_word%0d", i), 512'(bus.out), 512'(word_d(i)));
      if (i == 7) begin
        bus.in       = e_dig;
        bus.in_ready = 1'b1;
      end
      step();
      bus.in_ready = 1'b0;
    end
    check("t5_hand_ready", 512'(bus.out_ready), 512'(1));
    check("t5_hand_busy",  512'(bus.busy),      512'(1));
    check("t5_hand_ovr",   512'(bus.overrun),   512'(0));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_e_word%0d", i), 512'(bus.out), 512'(64'hAAAA_AAAA_AAAA_AAAA));
      check($sformatf("t5_e_last%0d", i), 512'(bus.is_last), 512'(i == 7));
      step();
    end
    bus.out_ack = 1'b0;
    check("t5_end_ready", 512'(bus.out_ready), 512'(0));
    check("t5_end_ovr",   512'(bus.overrun),   512'(0));
    step();

    // 6: async reset mid-stream after three acked words
    start_digest(d_dig, 1'b1);
    for (int i = 0; i < 3; i++) step();
    check("t6_pre_word3", 512'(bus.out), 512'(word_d(3)));
    bus.out_ack = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_rst_ready", 512'(bus.out_ready), 512'(0));
    check("t6_rst_busy",  512'(bus.busy),      512'(0));
    check("t6_rst_last",  512'(bus.is_last),   512'(0));
    @(negedge clk);
    reset = 1'b0;
    step();
    check("t6_idle_busy", 512'(bus.busy), 512'(0));
    check("t6_idle_out",  512'(bus.out),  512'(0));
    start_digest(d_dig, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t6_word%0d", i), 512'(bus.out), 512'(word_d(i)));
      step();
    end
    bus.out_ack = 1'b0;
    check("t6_end_ready", 512'(bus.out_ready), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
